fp16_vector_streamer: RTL and testbench

Sequencer that drives the producer side of the fp16 max-tracking interface (update / value / index).
- On a start pulse, reads a contiguous fp16 vector from a synchronous SRAM read port.
- Emits one update pulse per element, carrying the element value and its 0-based index.
- Sits between a vector buffer and the max/argmax unit. Signals completion with a single-cycle done pulse.

---
 rtl/fp16_vector_streamer_if.sv | 40 ++++
 rtl/fp16_vector_streamer.sv | 122 ++++++++++++
 tb/tb_fp16_vector_streamer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fp16_vector_streamer_if.sv
// Producer-side bundle of the fp16 vector streamer: control, SRAM read port and element stream.
// nan_count exists only when FP16_NAN_SKIP_EN is defined.
interface fp16_vector_streamer_if #(
  parameter int INDEX_WIDTH = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16
);
  logic                   start;
  logic                   abort;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [INDEX_WIDTH-1:0] length;
  logic                   busy;
  logic                   done;
  logic                   mem_rd_en;
  logic [ADDR_WIDTH-1:0]  mem_rd_addr;
  logic [DATA_WIDTH-1:0]  mem_rd_data;
  logic                   update;
  logic [DATA_WIDTH-1:0]  out_value;
  logic [INDEX_WIDTH-1:0] out_index;
  logic                   first;
`ifdef FP16_NAN_SKIP_EN
  logic [INDEX_WIDTH-1:0] nan_count;
`endif

  modport master (
    output start, abort, base_addr, length, mem_rd_data,
`ifdef FP16_NAN_SKIP_EN
    input  nan_count,
`endif
    input  busy, done, mem_rd_en, mem_rd_addr, update, out_value, out_index, first
  );

  modport slave (
    input  start, abort, base_addr, length, mem_rd_data,
`ifdef FP16_NAN_SKIP_EN
    output nan_count,
`endif
    output busy, done, mem_rd_en, mem_rd_addr, update, out_value, out_index, first
  );
endinterface

// File: rtl/fp16_vector_streamer.sv
// Streams a contiguous fp16 vector from a synchronous SRAM as indexed update pulses.
// Optional macro FP16_NAN_SKIP_EN suppresses updates for NaN elements and counts them.
module fp16_vector_streamer #(
  parameter int INDEX_WIDTH = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int RD_LATENCY  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp16_vector_streamer_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  logic [1:0]             state;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [INDEX_WIDTH-1:0] len_q;
  logic [INDEX_WIDTH-1:0] i_q;
  logic [RD_LATENCY-1:0]  vld_p;
  logic [INDEX_WIDTH-1:0] idx_p [RD_LATENCY];
  logic                   pipe_pending;
  logic                   tail_vld;
  logic                   tail_skip;
  logic                   upd;
  logic [INDEX_WIDTH-1:0] tail_idx;
  logic                   kill;

  assign kill = bus.abort && (state != IDLE);

  // Control FSM and issue counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_q <= '0;
      len_q  <= '0;
      i_q    <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.length != '0) begin
              state  <= ISSUE;
              base_q <= bus.base_addr;
              len_q  <= bus.length;
              i_q    <= '0;
            end else begin
              state <= FIN;
            end
          end
        end
        ISSUE: begin
          i_q <= i_q + INDEX_WIDTH'(1);
          if (i_q == len_q - INDEX_WIDTH'(1)) state <= DRAIN;
        end
        DRAIN:   if (!pipe_pending) state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read pipeline: {valid, index} travels alongside the SRAM access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int k = 0; k < RD_LATENCY; k++) idx_p[k] <= '0;
    end else if (kill) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= (state == ISSUE);
      idx_p[0] <= i_q;
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_p[k] <= vld_p[k-1];
        idx_p[k] <= idx_p[k-1];
      end
    end
  end

  // The tail stage is consumed this cycle, so DRAIN may leave once only it remains.
  always_comb begin
    pipe_pending = 1'b0;
    for (int k = 0; k < RD_LATENCY - 1; k++) pipe_pending = pipe_pending | vld_p[k];
  end

  assign tail_vld = vld_p[RD_LATENCY-1];
  assign tail_idx = idx_p[RD_LATENCY-1];

`ifdef FP16_NAN_SKIP_EN
  logic [INDEX_WIDTH-1:0] nan_q;

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
    return (v[14:10] == 5'h1f) && (v[9:0] != 10'd0);
  endfunction

  assign tail_skip = is_nan(bus.mem_rd_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          nan_q <= '0;
    else if (state == IDLE && bus.start) nan_q <= '0;
    else if (tail_vld && tail_skip)      nan_q <= nan_q + INDEX_WIDTH'(1);
  end

  assign bus.nan_count = nan_q;
`else
  assign tail_skip = 1'b0;
`endif

  assign upd             = tail_vld && !tail_skip;
  assign bus.update      = upd;
  assign bus.out_value   = upd ? bus.mem_rd_data : '0;
  assign bus.out_index   = upd ? tail_idx : '0;
  assign bus.first       = upd && (tail_idx == '0);
  assign bus.busy        = (state == ISSUE) || (state == DRAIN);
  assign bus.done        = (state == FIN);
  assign bus.mem_rd_en   = (state == ISSUE);
  assign bus.mem_rd_addr = base_q + ADDR_WIDTH'(i_q);
endmodule

// File: tb/tb_fp16_vector_streamer.sv
// Directed bench for fp16_vector_streamer: two instances (read latency 1 and 3) with SRAM models.
module tb_fp16_vector_streamer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        start_d, abort_d;
  logic [15:0] base_d, len_d;
  logic [15:0] mem [0:65535];
  int          total = 0;
  int          bad = 0;

  fp16_vector_streamer_if #(.INDEX_WIDTH(16), .DATA_WIDTH(16), .ADDR_WIDTH(16)) b1 ();
  fp16_vector_streamer_if #(.INDEX_WIDTH(16), .DATA_WIDTH(16), .ADDR_WIDTH(16)) b3 ();

  fp16_vector_streamer #(.INDEX_WIDTH(16), .DATA_WIDTH(16), .ADDR_WIDTH(16), .RD_LATENCY(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  fp16_vector_streamer #(.INDEX_WIDTH(16), .DATA_WIDTH(16), .ADDR_WIDTH(16), .RD_LATENCY(3))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  assign b1.start     = start_d & ~sel;
  assign b3.start     = start_d & sel;
  assign b1.abort     = abort_d & ~sel;
  assign b3.abort     = abort_d & sel;
  assign b1.base_addr = base_d;
  assign b3.base_addr = base_d;
  assign b1.length    = len_d;
  assign b3.length    = len_d;

  // SRAM models: data appears RD_LATENCY cycles after the strobe
  logic [15:0] rd1_q;
  logic [15:0] rd3_q [0:2];
  always @(posedge clk) begin
    if (b1.mem_rd_en) rd1_q <= mem[b1.mem_rd_addr];
    if (b3.mem_rd_en) rd3_q[0] <= mem[b3.mem_rd_addr];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign b1.mem_rd_data = rd1_q;
  assign b3.mem_rd_data = rd3_q[2];

  logic        o_busy, o_done, o_rd_en, o_upd, o_first;
  logic [15:0] o_addr, o_val, o_idx;
  assign o_busy  = sel ? b3.busy        : b1.busy;
  assign o_done  = sel ? b3.done        : b1.done;
  assign o_rd_en = sel ? b3.mem_rd_en   : b1.mem_rd_en;
  assign o_addr  = sel ? b3.mem_rd_addr : b1.mem_rd_addr;
  assign o_upd   = sel ? b3.update      : b1.update;
  assign o_first = sel ? b3.first       : b1.first;
  assign o_val   = sel ? b3.out_value   : b1.out_value;
  assign o_idx   = sel ? b3.out_index   : b1.out_index;
`ifdef FP16_NAN_SKIP_EN
  logic [15:0] o_nan;
  assign o_nan = sel ? b3.nan_count : b1.nan_count;
`endif

  function automatic bit is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1f) && (v[9:0] != 10'd0);
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
      end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, "busy", o_busy, 0);
    chk(tag, "done", o_done, 0);
    chk(tag, "rd_en", o_rd_en, 0);
    chk(tag, "addr", o_addr, 0);
    chk(tag, "update", o_upd, 0);
    chk(tag, "first", o_first, 0);
    chk(tag, "value", o_val, 0);
    chk(tag, "index", o_idx, 0);
  endtask

  // One pass starting in the current cycle (cycle 0); returns in the first cycle after it settles.
  task automatic run_pass(input string tag, input logic s, input logic [15:0] base, input logic [15:0] n,
                          input int lat, input int abort_at, input bit repulse);
    int          done_c, last, nan_exp, ni, live;
    logic [15:0] idx, a, ea;
    bit          e_rd, e_up;
    ni      = int'(n);
    done_c  = (ni == 0) ? 1 : ni + lat + 1;
    last    = (abort_at >= 0) ? abort_at + 1 : done_c + 1;
    nan_exp = 0;
    sel     = s;
    #1;
    chk(tag, "busy0", o_busy, 0);
    chk(tag, "done0", o_done, 0);
    start_d = 1'b1;
    base_d  = base;
    len_d   = n;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      start_d = repulse && (c == 2 || c == done_c);
      base_d  = 16'h5555;
      len_d   = 16'h0000;
      abort_d = (c == abort_at);
      live    = (abort_at < 0 || c <= abort_at) ? 1 : 0;
      e_rd    = (c <= ni) && (live != 0);
      chk(tag, "rd_en", o_rd_en, e_rd);
      ea = base + 16'(c - 1);
      if (e_rd) chk(tag, "addr", o_addr, ea);
      idx  = 16'(c - 1 - lat);
      a    = base + idx;
      e_up = (c >= 1 + lat) && (c <= ni + lat) && (live != 0);
`ifdef FP16_NAN_SKIP_EN
      if (e_up && is_nan(mem[a])) begin
        e_up = 1'b0;
        nan_exp++;
      end
`endif
      chk(tag, "update", o_upd, e_up);
      chk(tag, "first", o_first, e_up && (idx == 16'd0));
      if (e_up) begin
        chk(tag, "value", o_val, mem[a]);
        chk(tag, "index", o_idx, idx);
      end
      chk(tag, "done", o_done, (c == done_c) && (abort_at < 0));
      chk(tag, "busy", o_busy, (ni > 0) && (c <= ni + lat) && (live != 0));
`ifdef FP16_NAN_SKIP_EN
      if (c == done_c && abort_at < 0) chk(tag, "nan_count", o_nan, nan_exp);
`endif
    end
    start_d = 1'b0;
    abort_d = 1'b0;
  endtask

  initial begin
    sel = 1'b0; start_d = 1'b0; abort_d = 1'b0; base_d = '0; len_d = '0; rst_n = 1'b0;
    for (int k = 0; k < 65536; k++) mem[k] = 16'h0000;
    mem[16'h0010] = 16'h3C00; mem[16'h0011] = 16'hC000;
    mem[16'h0012] = 16'h4200; mem[16'h0013] = 16'h0000;
    mem[16'hFFFE] = 16'h1234; mem[16'hFFFF] = 16'hABCD; mem[16'h0000] = 16'h5A5A;
    for (int k = 0; k < 8; k++) mem[16'h0020 + k] = 16'h1000 + 16'(k * 16'h0111);
    mem[16'h0040] = 16'h7E00; mem[16'h0041] = 16'h3C00;
    mem[16'h0042] = 16'h7C01; mem[16'h0043] = 16'h4000;

    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0; #1; chk_idle("reset_l1");
    sel = 1'b1; #1; chk_idle("reset_l3");
`ifdef FP16_NAN_SKIP_EN
    chk("reset_l3", "nan_count", o_nan, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_pass("basic",    1'b0, 16'h0010, 16'd4, 1, -1, 1'b0);
    run_pass("len0",     1'b0, 16'h0010, 16'd0, 1, -1, 1'b0);
    run_pass("wrap_l3",  1'b1, 16'hFFFE, 16'd3, 3, -1, 1'b0);
    run_pass("abort",    1'b0, 16'h0020, 16'd8, 1,  4, 1'b0);
    @(posedge clk);
    #1;
    run_pass("restart",  1'b0, 16'h0020, 16'd8, 1, -1, 1'b0);
    run_pass("repulse",  1'b0, 16'h0010, 16'd4, 1, -1, 1'b1);
    run_pass("repulse3", 1'b1, 16'h0020, 16'd5, 3, -1, 1'b1);
    run_pass("nan",      1'b0, 16'h0040, 16'd4, 1, -1, 1'b0);

    // Reset in the middle of a pass clears everything and yields no done
    sel = 1'b0; start_d = 1'b1; base_d = 16'h0020; len_d = 16'd6;
    @(posedge clk);
    #1;
    start_d = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst", "busy_pre", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk("midrst", "done_after", o_done, 0);
      chk("midrst", "update_after", o_upd, 0);
    end

    run_pass("post_rst", 1'b0, 16'h0010, 16'd2, 1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
